// File: rtl/seg_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_pkg
// Description : Shared definitions for the 7-segment scan multiplexer.
//               Segment codes are {a,b,c,d,e,f,g,dp}, bit7..bit0, 1 = lit.
//               Provides the scan state enum and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_disp_pkg;

  localparam logic [7:0] SEG_0   = 8'hFC;
  localparam logic [7:0] SEG_1   = 8'h60;
  localparam logic [7:0] SEG_2   = 8'hDA;
  localparam logic [7:0] SEG_3   = 8'hF2;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'hB6;
  localparam logic [7:0] SEG_6   = 8'hBE;
  localparam logic [7:0] SEG_7   = 8'hE0;
  localparam logic [7:0] SEG_8   = 8'hFE;
  localparam logic [7:0] SEG_9   = 8'hE6;
  localparam logic [7:0] SEG_OFF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_disp_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_scan_mux_if
// Description : Data/display bundle of the scan multiplexer.
//   en         scan enable (0 = display dark)
//   load       1-cycle capture strobe for bcd_in/dp_in
//   bcd_in     4*NUM_DIGITS BCD word, digit 0 in the low nibble
//   dp_in      per-digit decimal points
//   seg_out    {a,b,c,d,e,f,g,dp}, active-high
//   dig_en     one-hot digit enable, active-high
//   frame_done 1-cycle pulse at the end of the last digit slot
//   master : upstream logic driving the value; slave : the scan multiplexer
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_disp_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [7:0]              seg_out;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_done;

  modport master (
    output en, load, bcd_in, dp_in,
    input  seg_out, dig_en, frame_done
  );

  modport slave (
    input  en, load, bcd_in, dp_in,
    output seg_out, dig_en, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg_bcd_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_bcd_decode
// Description : Combinational BCD to 7-segment decoder. Codes A-F are dark.
//   bcd  in  4  BCD digit
//   seg  out 7  {a,b,c,d,e,f,g}, active-high
// Revision    : 1.0 - initial release
// ============================================================================
module seg_bcd_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF[7:1];
    case (bcd)
      4'd0:    seg = SEG_0[7:1];
      4'd1:    seg = SEG_1[7:1];
      4'd2:    seg = SEG_2[7:1];
      4'd3:    seg = SEG_3[7:1];
      4'd4:    seg = SEG_4[7:1];
      4'd5:    seg = SEG_5[7:1];
      4'd6:    seg = SEG_6[7:1];
      4'd7:    seg = SEG_7[7:1];
      4'd8:    seg = SEG_8[7:1];
      4'd9:    seg = SEG_9[7:1];
      default: seg = SEG_OFF[7:1];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_disp_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_scan_mux
// Description : Time-multiplexed scan controller for an N-digit common-cathode
//               7-segment display. Each digit slot is CLK_DIV cycles: the first
//               BLANK_CYCLES are dark (anti-ghosting guard), the rest show the
//               digit. New values are double-buffered and take effect only at a
//               frame boundary so a frame is never torn.
//   clk     in  1     rising-edge clock
//   rst_n   in  1     asynchronous active-low reset
//   bus     slave     seg_disp_scan_mux_if (en, load, bcd_in, dp_in,
//                     seg_out, dig_en, frame_done)
// Build option : SEG_LZ_BLANK_EN - leading-zero blanking of digits above the
//                most significant non-zero digit (digit 0 always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_disp_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_disp_scan_mux_if.slave bus
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW  = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;

  logic [4*NUM_DIGITS-1:0] act_bcd, pend_bcd;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic                    pend_valid;

  logic                    frame_end;
  logic                    show_now;
  logic [3:0]              cur_bcd;
  logic                    cur_dp;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   cur_onehot;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [6:0]              seg7;

  logic [7:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   dig_reg;
  logic                    done_reg;

  // --------------------------------------------------------------------------
  // Scan FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Scan FSM: next state. BLANK/SHOW are purely a function of the slot
  // counter, so the state is re-derived from the next count each cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (!bus.en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        BLANK, SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
          state_nxt = (cnt_nxt < CNT_SHOW) ? BLANK : SHOW;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  assign frame_end = (state != IDLE) && (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign show_now  = bus.en && (state == SHOW);

  // --------------------------------------------------------------------------
  // Double buffer. A load landing exactly on the boundary bypasses pending so
  // it is not delayed by a whole frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_bcd    <= '0;
      act_dp     <= '0;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else if (frame_end) begin
      if (bus.load) begin
        act_bcd <= bus.bcd_in;
        act_dp  <= bus.dp_in;
      end else if (pend_valid) begin
        act_bcd <= pend_bcd;
        act_dp  <= pend_dp;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_bcd   <= bus.bcd_in;
      pend_dp    <= bus.dp_in;
      pend_valid <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero detection on the active word
  // --------------------------------------------------------------------------
`ifdef SEG_LZ_BLANK_EN
  // zero_from[k] = digits k..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS:1] zero_from;
  assign zero_from[NUM_DIGITS] = 1'b1;
  assign lz_blank[0]           = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
    assign zero_from[k] = zero_from[k+1] && (act_bcd[4*k +: 4] == 4'd0);
    assign lz_blank[k]  = zero_from[k];
  end
`else
  assign lz_blank = '0;
`endif

  // --------------------------------------------------------------------------
  // Digit select
  // --------------------------------------------------------------------------
  always_comb begin
    cur_bcd    = 4'd0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    cur_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_bcd       = act_bcd[4*k +: 4];
        cur_dp        = act_dp[k];
        cur_lz        = lz_blank[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  seg_bcd_decode u_decode (
    .bcd (cur_bcd),
    .seg (seg7)
  );

  // --------------------------------------------------------------------------
  // Output registers: one cycle behind cnt/idx. Gating with en darkens the
  // display on the cycle right after en falls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg  <= SEG_OFF;
      dig_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      if (show_now) begin
        seg_reg <= {(cur_lz ? 7'd0 : seg7), cur_dp};
        dig_reg <= cur_onehot;
      end else begin
        seg_reg <= SEG_OFF;
        dig_reg <= '0;
      end
      done_reg <= show_now && (cnt == CNT_LAST) && (idx == IDX_LAST);
    end
  end

  assign bus.seg_out    = seg_reg;
  assign bus.dig_en     = dig_reg;
  assign bus.frame_done = done_reg;

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_disp_scan_mux
// Description : Self-checking bench for seg_disp_scan_mux (4 digits,
//               8 cycles per slot, 2 guard cycles). Expected outputs come from
//               a run-length model: position in the scan is derived from the
//               number of consecutive enabled clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_disp_scan_mux;

  localparam int ND    = 4;
  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * CD;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] LZ0 = 8'h00;
`else
  localparam logic [7:0] LZ0 = 8'hFC;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_disp_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_disp_scan_mux #(
    .NUM_DIGITS   (ND),
    .CLK_DIV      (CD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int         runs;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pv;
  logic [12:0] e_out;   // {seg, dig, frame_done}

  function automatic logic [7:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 8'hFC;  4'd1: dec = 8'h60;  4'd2: dec = 8'hDA;
      4'd3: dec = 8'hF2;  4'd4: dec = 8'h66;  4'd5: dec = 8'hB6;
      4'd6: dec = 8'hBE;  4'd7: dec = 8'hE0;  4'd8: dec = 8'hFE;
      4'd9: dec = 8'hE6;  default: dec = 8'h00;
    endcase
  endfunction

  // Outputs after an edge reflect scan position runs-1 (runs = enabled edges
  // before this one), provided en is still high at this edge.
  function automatic logic [12:0] exp_out(input int n, input logic en,
                                          input logic [15:0] act,
                                          input logic [3:0] dp);
    int p;
    int slot;
    int c;
    logic [7:0] sg;
    logic [3:0] dg;
    exp_out = '0;
    if (en && n >= 1) begin
      p    = n - 1;
      slot = (p / CD) % ND;
      c    = p % CD;
      if (c >= BC) begin
        sg = dec(act[slot*4 +: 4]);
`ifdef SEG_LZ_BLANK_EN
        if (slot > 0 && (act >> (slot*4)) == 16'd0) sg = 8'h00;
`endif
        sg[0]   = dp[slot];
        dg      = 4'(1 << slot);
        exp_out = {sg, dg, (slot == ND-1 && c == CD-1)};
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runs      <= 0;
      m_act     <= '0;
      m_pend    <= '0;
      m_act_dp  <= '0;
      m_pend_dp <= '0;
      m_pv      <= 1'b0;
      e_out     <= '0;
    end else begin
      e_out <= exp_out(runs, bus.en, m_act, m_act_dp);
      if (runs >= 1 && ((runs - 1) % FRAME) == FRAME - 1) begin
        if (bus.load) begin
          m_act    <= bus.bcd_in;
          m_act_dp <= bus.dp_in;
        end else if (m_pv) begin
          m_act    <= m_pend;
          m_act_dp <= m_pend_dp;
        end
        m_pv <= 1'b0;
      end else if (bus.load) begin
        m_pend    <= bus.bcd_in;
        m_pend_dp <= bus.dp_in;
        m_pv      <= 1'b1;
      end
      runs <= bus.en ? runs + 1 : 0;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus and checking
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int k     = 0;
  int first_lit = 0;
  int first_fd  = 0;
  int fd_cnt    = 0;

  task automatic check(input string nm, input logic [15:0] got,
                       input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s k=%0d got=%h want=%h", nm, k, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
    check("scan", {3'b0, bus.seg_out, bus.dig_en, bus.frame_done},
          {3'b0, e_out});
  endtask

  task automatic goto(input int n);
    while (k < n) tick();
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp);
    bus.load   = 1'b1;
    bus.bcd_in = v;
    bus.dp_in  = dp;
    tick();
    bus.load   = 1'b0;
    bus.bcd_in = 16'h9999;
    bus.dp_in  = 4'b1111;
  endtask

  initial begin
    rst_n      = 1'b1;
    bus.en     = 1'b0;
    bus.load   = 1'b0;
    bus.bcd_in = '0;
    bus.dp_in  = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_seg", {8'h00, bus.seg_out}, 16'h0000);
    check("reset_dig", {12'h000, bus.dig_en}, 16'h0000);
    check("reset_fd",  {15'h0, bus.frame_done}, 16'h0000);

    // 1. free-running scan of the reset value (all zeros -> FC)
    rst_n  = 1'b1;
    bus.en = 1'b1;
    k      = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (first_lit == 0 && bus.dig_en != 4'b0) first_lit = k;
      if (bus.frame_done) begin
        fd_cnt++;
        if (first_fd == 0) first_fd = k;
      end
      if (k == 4)  check("slot0", {bus.seg_out, bus.dig_en}, 12'hFC1);
      if (k == 10) check("guard", {bus.seg_out, bus.dig_en}, 12'h000);
      if (k == 12) check("slot1", {bus.seg_out, bus.dig_en}, 12'hFC2);
      if (k == 20) check("slot2", {bus.seg_out, bus.dig_en}, 12'hFC4);
      if (k == 28) check("slot3", {bus.seg_out, bus.dig_en}, 12'hFC8);
    end
    check("first_lit_k", first_lit[15:0], 16'd4);
    check("first_fd_k",  first_fd[15:0],  16'd33);
    check("fd_count",    fd_cnt[15:0],    16'd2);

    // 2. mid-frame load: current frame untouched, next frame shows it
    load_word(16'h1234, 4'b0100);
    goto(86);  check("no_tear",   {bus.seg_out, bus.dig_en}, 12'hFC4);
    goto(100); check("new_d0",    {bus.seg_out, bus.dig_en}, 12'h661);
    goto(108); check("new_d1",    {bus.seg_out, bus.dig_en}, 12'hF22);
    goto(116); check("new_d2_dp", {bus.seg_out, bus.dig_en}, 12'hDB4);
    goto(124); check("new_d3",    {bus.seg_out, bus.dig_en}, 12'h608);

    // 3./4. load on the boundary cycle goes straight to active
    goto(128);
    load_word(16'h00A7, 4'b0000);
    goto(132); check("bnd_d0",  {bus.seg_out, bus.dig_en}, 12'hE01);
    goto(140); check("hex_dark", {bus.seg_out, bus.dig_en}, 12'h002);
    goto(150); check("d2_zero", {bus.seg_out, bus.dig_en}, {LZ0, 4'b0100});

    // 5. en dropped mid-SHOW, then re-raised
    bus.en = 1'b0;
    tick();    check("en_off", {bus.seg_out, bus.dig_en}, 12'h000);
    goto(155);
    bus.en = 1'b1;
    goto(158); check("restart_blank", {bus.seg_out, bus.dig_en}, 12'h000);
    tick();    check("restart_d0",    {bus.seg_out, bus.dig_en}, 12'hE01);

    // 6. leading zeros
    load_word(16'h0050, 4'b0000);
    goto(191); check("lz_d0", {bus.seg_out, bus.dig_en}, 12'hFC1);
    goto(199); check("lz_d1", {bus.seg_out, bus.dig_en}, 12'hB62);
    goto(207); check("lz_d2", {bus.seg_out, bus.dig_en}, {LZ0, 4'b0100});
    goto(215); check("lz_d3", {bus.seg_out, bus.dig_en}, {LZ0, 4'b1000});

    // asynchronous reset in the middle of a lit slot
    goto(217); check("pre_rst", {bus.seg_out, bus.dig_en}, {LZ0, 4'b1000});
    #2 rst_n = 1'b0;
    #1 check("async_rst", {3'b0, bus.seg_out, bus.dig_en, bus.frame_done},
             16'h0000);
    tick();
    tick();
    rst_n = 1'b1;

    // two pending loads in one frame: the later one wins
    goto(230); load_word(16'h9876, 4'b1010);
    goto(240); load_word(16'h4321, 4'b0001);
    goto(255); check("last_wins_d0", {bus.seg_out, bus.dig_en}, 12'h611);
    goto(263); check("last_wins_d1", {bus.seg_out, bus.dig_en}, 12'hDA2);
    goto(320);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
